me_controller: RTL and testbench
================================

# me_controller

Sequencing controller for the 1-D systolic motion-estimation array of BLOCK processing elements (PE k evaluates horizontal offset k). It walks a BLOCK×BLOCK reference block against V_POS vertical search positions and issues reference and search memory addresses. It drives each PE's `s1s2_mux` and `new_dist` strobes and tells the downstream minimum comparator which PE's `accumulate` is final in each cycle. Search positions run back-to-back with no idle gap.

## Interface
- BLOCK, 16, block edge in pixels; also the PE count (N = BLOCK)
- V_POS, 16, vertical search positions
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request; accepted only in IDLE
- busy  out  1  high from the first RUN cycle through the DONE cycle
- done  out  1  one-cycle pulse at the end of a search
- r_addr  out  clog2(BLOCK²)  reference memory raster address
- s1_row, s2_row  out  clog2(V_POS+BLOCK-1)  search memory row for streams s1 and s2
- s1_col, s2_col  out  clog2(2·BLOCK-1)  search memory column for streams s1 and s2
- s1s2_mux  out  BLOCK  per-PE select; bit k = 1 selects s1, 0 selects s2
- new_dist  out  BLOCK  per-PE accumulator clear/load strobe
- cmp_valid  out  1  PE `cmp_pe` holds a final distortion this cycle
- cmp_pe  out  clog2(BLOCK)  horizontal offset (PE index)
- cmp_vpos  out  clog2(V_POS)  vertical position of that distortion

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE when the final compare is issued.
  - DONE → IDLE unconditionally.
  - `start` is ignored outside IDLE.
- Run-time counter c increments every RUN cycle, starting at 0.
- Schedule index g: address index g = c; control index g = c-1. One cycle of lead covers the synchronous-read memories.
- Schedule decomposition:
  - Q = BLOCK²
  - v = g / Q
  - t = g mod Q
  - i = t / BLOCK
  - j = t mod BLOCK
- Addresses, driven while g < V_POS·Q:
  - r_addr = t
  - s1_row = v + i
  - s1_col = j
- s2 stream:
  - s2_row = the s1_row value issued for index g-BLOCK, i.e. delayed BLOCK cycles; this stays valid across position boundaries.
  - s2_col = BLOCK + j.
  - s2 is don't-care for g < BLOCK.
  - From g ≥ V_POS·Q, s1/r addresses are don't-care, but s2 continues for g < V_POS·Q + BLOCK.
- Controls for index g:
  - s1s2_mux[k] = (g mod BLOCK ≥ k).
  - new_dist[k] = (g mod Q == k) and g < V_POS·Q.
- PE k consumes reference pixel g-k. Its distortion for position v is final one cycle after its last pixel.
- Compare output: cmp_valid=1, cmp_pe=k, cmp_vpos=v at c = (v+1)·Q + k + 1, for each v < V_POS and k < BLOCK. This is exactly one compare per cycle.
- The final compare is at c = V_POS·Q + BLOCK. `done` pulses the next cycle.
- Reset, including mid-run: FSM to IDLE, c cleared. The next `start` restarts from g=0.

## Timing
- All outputs are registered. Reset value of every output is 0.
- In IDLE, every output is 0.
- Address outputs are driven at g = c.
- Control outputs:
  - s1s2_mux and new_dist are driven at g = c-1.
  - The s1s2_mux/new_dist values for index g appear exactly one cycle after that index's addresses.
  - s1s2_mux and new_dist are 0 at c=0.
- Latency and run length:
  - start→first address: 1 cycle.
  - Search length: V_POS·Q + BLOCK + 1 RUN cycles, plus 1 DONE cycle.
- Boundary cycles:
  - Position boundary (t=0, v>0): new_dist[0] and cmp_valid for (v-1, PE 0) occur in the same cycle as each other. That cmp_valid samples the value before the clear edge.

## Structure
- Shared package `me_pkg` holds:
  - default BLOCK/V_POS
  - width functions (address, row, column, PE index)
  - FSM state enum (IDLE, RUN, DONE)
- Sub-module `me_row_delay`: BLOCK-deep shift register producing s2_row from s1_row.
- The rest is flat: counter, decode, FSM.

## Test plan
All scenarios use BLOCK=4, V_POS=2 (Q=16).
- Reset asserted → every output 0, busy=0; `start` seen during reset is ignored.
- start → r_addr=0..15 at c=0..15 and 0..15 again at c=16..31; new_dist[k] pulses at c=k+1 and c=17+k; at c=3, s1s2_mux=4'b0111.
- c=16 → s1_row=1, s1_col=0, s2_row=3, s2_col=4; c=21 → s1_row=2, s1_col=1, s2_row=1, s2_col=5.
- cmp_valid at c=17..20 with cmp_pe=0..3, cmp_vpos=0; at c=33..36 with cmp_pe=0..3, cmp_vpos=1; done at c=37; IDLE at c=38.
- start re-pulsed at c=5 → no effect; the run still ends at c=37.
- reset at c=10, then start → outputs 0 during reset; the new run restarts r_addr at 0 and the full 37-cycle sequence repeats.

Source files
------------

// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation controller: default geometry,
// port-width helpers and the sequencing FSM state encoding.
package me_pkg;

  localparam int BLOCK_DEF = 16;
  localparam int V_POS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } me_state_t;

  // ceil(log2(n)), never narrower than one bit
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int addr_w(input int block);
    return clog2_min1(block * block);
  endfunction

  function automatic int row_w(input int block, input int v_pos);
    return clog2_min1(v_pos + block - 1);
  endfunction

  function automatic int col_w(input int block);
    return clog2_min1(2 * block - 1);
  endfunction

  function automatic int pe_w(input int block);
    return clog2_min1(block);
  endfunction

  function automatic int vpos_w(input int v_pos);
    return clog2_min1(v_pos);
  endfunction

  // run counter must reach V_POS*BLOCK^2 + BLOCK
  function automatic int cnt_w(input int block, input int v_pos);
    return clog2_min1(v_pos * block * block + block + 1);
  endfunction

endpackage

// File: rtl/me_row_delay.sv
// Fixed-depth shift register: the s2 search row is the s1 row issued DEPTH
// cycles earlier, so this line simply replays it.
module me_row_delay #(
  parameter int DEPTH = 16,
  parameter int W     = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_r [DEPTH];

  // Shift one stage per cycle; flush to zero whenever the search is not running
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= {W{1'b0}};
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= {W{1'b0}};
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/me_controller.sv
// Sequencer for the 1-D systolic motion-estimation array. A single run counter
// drives the memory addresses (one cycle ahead, covering synchronous reads),
// the per-PE mux/clear strobes and the comparator hand-off. All outputs are
// computed from the next counter value and registered.
module me_controller
  import me_pkg::*;
#(
  parameter  int BLOCK = BLOCK_DEF,
  parameter  int V_POS = V_POS_DEF,
  localparam int AW    = addr_w(BLOCK),
  localparam int RW    = row_w(BLOCK, V_POS),
  localparam int CLW   = col_w(BLOCK),
  localparam int PW    = pe_w(BLOCK),
  localparam int VPW   = vpos_w(V_POS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    r_addr,
  output logic [RW-1:0]    s1_row,
  output logic [RW-1:0]    s2_row,
  output logic [CLW-1:0]   s1_col,
  output logic [CLW-1:0]   s2_col,
  output logic [BLOCK-1:0] s1s2_mux,
  output logic [BLOCK-1:0] new_dist,
  output logic             cmp_valid,
  output logic [PW-1:0]    cmp_pe,
  output logic [VPW-1:0]   cmp_vpos
);

  localparam int Q      = BLOCK * BLOCK;
  localparam int VQ     = V_POS * Q;
  localparam int LAST_C = VQ + BLOCK;
  localparam int CW     = cnt_w(BLOCK, V_POS);

  me_state_t      state_r, state_nxt_s;
  logic [CW-1:0]  c_r, c_nxt_s;

  logic             busy_r, done_r, cmp_valid_r, cmp_valid_nxt_s;
  logic [AW-1:0]    r_addr_r, r_addr_nxt_s;
  logic [RW-1:0]    s1_row_r, s1_row_nxt_s, s2_row_s;
  logic [CLW-1:0]   s1_col_r, s1_col_nxt_s, s2_col_r, s2_col_nxt_s;
  logic [BLOCK-1:0] mux_r, mux_nxt_s, nd_r, nd_nxt_s;
  logic [PW-1:0]    cmp_pe_r, cmp_pe_nxt_s;
  logic [VPW-1:0]   cmp_vpos_r, cmp_vpos_nxt_s;

  // FSM next state and run counter: count every RUN cycle, leave after the final compare
  always_comb begin
    state_nxt_s = state_r;
    c_nxt_s     = c_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
        c_nxt_s = {CW{1'b0}};
      end
      RUN: begin
        if (c_r == CW'(LAST_C)) begin
          state_nxt_s = DONE;
          c_nxt_s     = {CW{1'b0}};
        end else begin
          state_nxt_s = RUN;
          c_nxt_s     = c_r + CW'(1);
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        c_nxt_s     = {CW{1'b0}};
      end
      default: begin
        state_nxt_s = IDLE;
        c_nxt_s     = {CW{1'b0}};
      end
    endcase
  end

  // Decode the upcoming counter value into addresses (index c) and controls (index c-1)
  always_comb begin
    int g;
    int t;
    int gc;
    int h;
    g               = int'(c_nxt_s);
    t               = g % Q;
    gc              = g - 1;
    h               = g - Q - 1;
    r_addr_nxt_s    = {AW{1'b0}};
    s1_row_nxt_s    = {RW{1'b0}};
    s1_col_nxt_s    = {CLW{1'b0}};
    s2_col_nxt_s    = {CLW{1'b0}};
    mux_nxt_s       = {BLOCK{1'b0}};
    nd_nxt_s        = {BLOCK{1'b0}};
    cmp_valid_nxt_s = 1'b0;
    cmp_pe_nxt_s    = {PW{1'b0}};
    cmp_vpos_nxt_s  = {VPW{1'b0}};
    if (state_nxt_s == RUN) begin
      if (g < VQ) begin
        r_addr_nxt_s = AW'(t);
        s1_row_nxt_s = RW'(g / Q + t / BLOCK);
        s1_col_nxt_s = CLW'(t % BLOCK);
      end else begin
        r_addr_nxt_s = {AW{1'b0}};
      end
      if (g < VQ + BLOCK) begin
        s2_col_nxt_s = CLW'(BLOCK + g % BLOCK);
      end else begin
        s2_col_nxt_s = {CLW{1'b0}};
      end
      if (g >= 1) begin
        for (int k = 0; k < BLOCK; k++) begin
          mux_nxt_s[k] = ((gc % BLOCK) >= k);
          nd_nxt_s[k]  = ((gc % Q) == k) && (gc < VQ);
        end
      end else begin
        mux_nxt_s = {BLOCK{1'b0}};
      end
      // PE k's distortion for position v is final at c = (v+1)*Q + k + 1
      if ((h >= 0) && ((h % Q) < BLOCK) && ((h / Q) < V_POS)) begin
        cmp_valid_nxt_s = 1'b1;
        cmp_pe_nxt_s    = PW'(h % Q);
        cmp_vpos_nxt_s  = VPW'(h / Q);
      end else begin
        cmp_valid_nxt_s = 1'b0;
      end
    end else begin
      cmp_valid_nxt_s = 1'b0;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      c_r         <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      r_addr_r    <= {AW{1'b0}};
      s1_row_r    <= {RW{1'b0}};
      s1_col_r    <= {CLW{1'b0}};
      s2_col_r    <= {CLW{1'b0}};
      mux_r       <= {BLOCK{1'b0}};
      nd_r        <= {BLOCK{1'b0}};
      cmp_valid_r <= 1'b0;
      cmp_pe_r    <= {PW{1'b0}};
      cmp_vpos_r  <= {VPW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      c_r         <= c_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == DONE);
      r_addr_r    <= r_addr_nxt_s;
      s1_row_r    <= s1_row_nxt_s;
      s1_col_r    <= s1_col_nxt_s;
      s2_col_r    <= s2_col_nxt_s;
      mux_r       <= mux_nxt_s;
      nd_r        <= nd_nxt_s;
      cmp_valid_r <= cmp_valid_nxt_s;
      cmp_pe_r    <= cmp_pe_nxt_s;
      cmp_vpos_r  <= cmp_vpos_nxt_s;
    end
  end

  me_row_delay #(
    .DEPTH (BLOCK),
    .W     (RW)
  ) u_row_delay (
    .clock (clock),
    .reset (reset),
    .clr   (state_nxt_s != RUN),
    .din   (s1_row_r),
    .dout  (s2_row_s)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign r_addr    = r_addr_r;
  assign s1_row    = s1_row_r;
  assign s2_row    = s2_row_s;
  assign s1_col    = s1_col_r;
  assign s2_col    = s2_col_r;
  assign s1s2_mux  = mux_r;
  assign new_dist  = nd_r;
  assign cmp_valid = cmp_valid_r;
  assign cmp_pe    = cmp_pe_r;
  assign cmp_vpos  = cmp_vpos_r;

endmodule

// File: tb/tb_me_controller.sv
// Self-checking bench for me_controller with BLOCK=4, V_POS=2. Expected
// per-cycle outputs come from a schedule table built by walking
// positions/rows/columns and PE/position pairs.
module tb_me_controller;

  localparam int B      = 4;
  localparam int VP     = 2;
  localparam int Q      = B * B;
  localparam int VQ     = VP * Q;
  localparam int LAST_C = VQ + B;      // final RUN cycle (36)
  localparam int DONE_C = LAST_C + 1;  // 37
  localparam int IDLE_C = LAST_C + 2;  // 38
  localparam int NC     = IDLE_C + 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b1;
  logic         busy, done;
  logic [3:0]   r_addr;
  logic [2:0]   s1_row, s2_row, s1_col, s2_col;
  logic [B-1:0] s1s2_mux, new_dist;
  logic         cmp_valid;
  logic [1:0]   cmp_pe;
  logic [0:0]   cmp_vpos;

  int n_pass   = 0;
  int n_checks = 0;

  logic [31:0] e_raddr [NC];
  logic [31:0] e_s1r   [NC];
  logic [31:0] e_s1c   [NC];
  logic [31:0] e_s2r   [NC];
  logic [31:0] e_s2c   [NC];
  logic [31:0] e_mux   [NC];
  logic [31:0] e_nd    [NC];
  logic [31:0] e_cv    [NC];
  logic [31:0] e_cpe   [NC];
  logic [31:0] e_cvp   [NC];

  me_controller #(.BLOCK(B), .V_POS(VP)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .r_addr    (r_addr),
    .s1_row    (s1_row),
    .s2_row    (s2_row),
    .s1_col    (s1_col),
    .s2_col    (s2_col),
    .s1s2_mux  (s1s2_mux),
    .new_dist  (new_dist),
    .cmp_valid (cmp_valid),
    .cmp_pe    (cmp_pe),
    .cmp_vpos  (cmp_vpos)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (observed timeout, expected finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Build the expected schedule from the array's dataflow rules
  task automatic build_model();
    int g;
    for (int c = 0; c < NC; c++) begin
      e_raddr[c] = 0; e_s1r[c] = 0; e_s1c[c] = 0; e_s2r[c] = 0; e_s2c[c] = 0;
      e_mux[c] = 0; e_nd[c] = 0; e_cv[c] = 0; e_cpe[c] = 0; e_cvp[c] = 0;
    end
    // reference pixel (i,j) of position v is fetched at cycle v*Q + i*B + j
    for (int v = 0; v < VP; v++)
      for (int i = 0; i < B; i++)
        for (int j = 0; j < B; j++) begin
          g = v * Q + i * B + j;
          e_raddr[g] = i * B + j;
          e_s1r[g]   = v + i;
          e_s1c[g]   = j;
        end
    for (int c = B; c < VQ + B; c++) begin
      e_s2r[c] = e_s1r[c - B];
      e_s2c[c] = B + (c % B);
    end
    // controls trail addresses by one cycle
    for (int c = 1; c <= LAST_C; c++)
      e_mux[c] = (32'd1 << ((c - 1) % B + 1)) - 32'd1;
    for (int v = 0; v < VP; v++)
      for (int k = 0; k < B; k++) begin
        e_nd[v * Q + k + 1] = e_nd[v * Q + k + 1] | (32'd1 << k);
        e_cv[(v + 1) * Q + k + 1]  = 1;
        e_cpe[(v + 1) * Q + k + 1] = k;
        e_cvp[(v + 1) * Q + k + 1] = v;
      end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    chk({tag, ".done"},  32'(done), 32'd0);
    chk({tag, ".raddr"}, 32'(r_addr), 32'd0);
    chk({tag, ".s1row"}, 32'(s1_row), 32'd0);
    chk({tag, ".s2row"}, 32'(s2_row), 32'd0);
    chk({tag, ".s1col"}, 32'(s1_col), 32'd0);
    chk({tag, ".s2col"}, 32'(s2_col), 32'd0);
    chk({tag, ".mux"},   32'(s1s2_mux), 32'd0);
    chk({tag, ".nd"},    32'(new_dist), 32'd0);
    chk({tag, ".cv"},    32'(cmp_valid), 32'd0);
    chk({tag, ".cpe"},   32'(cmp_pe), 32'd0);
    chk({tag, ".cvp"},   32'(cmp_vpos), 32'd0);
  endtask

  task automatic check_cycle(input string run, input int c);
    string p;
    p = $sformatf("%s.c%0d", run, c);
    if (c == IDLE_C) begin
      check_zero(p);
    end else begin
      chk({p, ".busy"}, 32'(busy), 32'd1);
      chk({p, ".done"}, 32'(done), (c == DONE_C) ? 32'd1 : 32'd0);
      chk({p, ".cv"},   32'(cmp_valid), e_cv[c]);
      if (c <= LAST_C) begin
        chk({p, ".mux"}, 32'(s1s2_mux), e_mux[c]);
        chk({p, ".nd"},  32'(new_dist), e_nd[c]);
      end
      if (e_cv[c] == 32'd1) begin
        chk({p, ".cpe"}, 32'(cmp_pe), e_cpe[c]);
        chk({p, ".cvp"}, 32'(cmp_vpos), e_cvp[c]);
      end
      if (c < VQ) begin
        chk({p, ".raddr"}, 32'(r_addr), e_raddr[c]);
        chk({p, ".s1row"}, 32'(s1_row), e_s1r[c]);
        chk({p, ".s1col"}, 32'(s1_col), e_s1c[c]);
      end
      if (c >= B && c < VQ + B) begin
        chk({p, ".s2row"}, 32'(s2_row), e_s2r[c]);
        chk({p, ".s2col"}, 32'(s2_col), e_s2c[c]);
      end
    end
  endtask

  // Launch a run; re-pulse start at stray_c; stop observing after abort_c
  task automatic do_run(input string run, input int stray_c, input int abort_c);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < NC; c++) begin
      check_cycle(run, c);
      if (c == abort_c) break;
      start = (c == stray_c);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic mid_reset(input string tag);
    reset = 1'b1;
    start = 1'b1;
    #1;
    check_zero({tag, ".async"});
    tick();
    check_zero({tag, ".held"});
    reset = 1'b0;
    start = 1'b0;
    tick();
    check_zero({tag, ".post"});
  endtask

  initial begin
    int gap;
    build_model();

    // reset with start held high: outputs stay 0, start ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero($sformatf("rst%0d", i));
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    check_zero("idle_after_rst");

    // full run with start re-pulsed at c=5
    do_run("runA", 5, -1);

    // stray start at a random point
    do_run("runB", $urandom_range(1, LAST_C - 1), -1);

    // reset at c=10, then a complete run
    do_run("runC", -1, 10);
    mid_reset("rstC");
    do_run("runC2", -1, -1);

    // reset at a random cycle, random idle gap, then a complete run
    do_run("runD", -1, $urandom_range(2, LAST_C - 2));
    mid_reset("rstD");
    gap = $urandom_range(0, 5);
    for (int i = 0; i < gap; i++) begin
      tick();
      check_zero($sformatf("gap%0d", i));
    end
    do_run("runD2", $urandom_range(0, LAST_C), -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
